// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Purpose  : Opcodes, FSM state encodings and flag helper for alu_seq.
// Revision : 1.0
// ============================================================================
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_ZERO = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_DONE     = 2'd2
  } alu_state_t;

  // Returns {N, Z, P} for a zero-extended value whose sign bit sits at width-1.
  function automatic logic [2:0] alu_flags(input logic [31:0] value,
                                           input int unsigned width);
    logic n;
    logic z;
    n = value[5'(width - 1)];
    z = (value == 32'd0);
    return {n, z, !n && !z};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : Shift-add unsigned multiplier, one partial product per cycle.
//            Built only when ALU_SEQ_MUL_EN is defined.
// Revision : 1.0
// ============================================================================
`ifdef ALU_SEQ_MUL_EN
module alu_mul_seq #(
  parameter int DATA_SIZE = 16,
  parameter int CNT_W     = $clog2(DATA_SIZE) + 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic [DATA_SIZE-1:0]   A,
  input  logic [DATA_SIZE-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [2*DATA_SIZE-1:0] product
);

  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(DATA_SIZE - 1);

  logic [2*DATA_SIZE-1:0] r_mcand;
  logic [2*DATA_SIZE-1:0] r_acc;
  logic [DATA_SIZE-1:0]   r_mplier;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= {{DATA_SIZE{1'b0}}, A};
        r_mplier <= B;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end else if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        // The final partial product lands on the same edge that raises done.
        if (r_cnt == c_last_step) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_acc;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : 8-op registered ALU with valid/ready handshake and N/Z/P, carry,
//            overflow flags. Define ALU_SEQ_MUL_EN to build the multi-cycle
//            multiplier for opcode 111 (otherwise it behaves like ZERO).
// Revision : 1.0
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int CNT_W     = $clog2(DATA_SIZE) + 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2:0]           ALUK,
  input  logic [DATA_SIZE-1:0] OP_A,
  input  logic [DATA_SIZE-1:0] OP_B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [DATA_SIZE-1:0] Y,
  output logic                 CYO,
  output logic                 OVF,
  output logic                 N,
  output logic                 Z,
  output logic                 P
);

  localparam int c_msb = DATA_SIZE - 1;

  alu_state_t             r_state;
  logic [DATA_SIZE-1:0]   r_y;
  logic                   r_cyo;
  logic                   r_ovf;
  logic                   r_n;
  logic                   r_z;
  logic                   r_p;
  logic                   r_out_valid;

  logic                   w_accept;
  logic                   w_is_mul;
  logic                   w_engine_free;
  logic [DATA_SIZE:0]     w_add;
  logic [DATA_SIZE:0]     w_sub;
  logic [2*DATA_SIZE-1:0] w_shl;
  logic [DATA_SIZE-1:0]   w_y;
  logic                   w_cyo;
  logic                   w_ovf;
  logic [2:0]             w_nzp;

`ifdef ALU_SEQ_MUL_EN
  logic                   w_mul_start;
  logic                   w_mul_busy;
  logic                   w_mul_done;
  logic [2*DATA_SIZE-1:0] w_product;
  logic [2:0]             w_mul_nzp;

  assign w_is_mul    = (ALUK == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  alu_mul_seq #(
    .DATA_SIZE (DATA_SIZE),
    .CNT_W     (CNT_W)
  ) u_mul (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .start   (w_mul_start),
    .A       (OP_A),
    .B       (OP_B),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_product)
  );

  assign w_engine_free = !w_mul_busy;
  assign w_mul_nzp     = alu_flags(32'(w_product[DATA_SIZE-1:0]), DATA_SIZE);
`else
  assign w_is_mul      = 1'b0;
  assign w_engine_free = 1'b1;
`endif

  // A held result frees the input side in the same cycle it is consumed.
  assign IN_READY = w_engine_free &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DONE) && OUT_READY));
  assign w_accept = IN_VALID && IN_READY;

  assign w_add = {1'b0, OP_A} + {1'b0, OP_B};
  assign w_sub = {1'b0, OP_A} + {1'b0, ~OP_B} + {{DATA_SIZE{1'b0}}, 1'b1};
  // Bit DATA_SIZE of the widened shift is the last bit pushed out of A.
  assign w_shl = {{DATA_SIZE{1'b0}}, OP_A} << OP_B[CNT_W-2:0];

  always_comb begin
    w_y   = '0;
    w_cyo = 1'b0;
    w_ovf = 1'b0;
    case (ALUK)
      OP_ADD: begin
        w_y   = w_add[DATA_SIZE-1:0];
        w_cyo = w_add[DATA_SIZE];
        w_ovf = (OP_A[c_msb] == OP_B[c_msb]) && (w_add[c_msb] != OP_A[c_msb]);
      end
      OP_AND: w_y = OP_A & OP_B;
      OP_NOT: w_y = ~OP_A;
      OP_SUB: begin
        w_y   = w_sub[DATA_SIZE-1:0];
        w_cyo = w_sub[DATA_SIZE];
        w_ovf = (OP_A[c_msb] != OP_B[c_msb]) && (w_sub[c_msb] != OP_A[c_msb]);
      end
      OP_XOR: w_y = OP_A ^ OP_B;
      OP_SHL: begin
        w_y   = w_shl[DATA_SIZE-1:0];
        w_cyo = w_shl[DATA_SIZE];
      end
      default: w_y = '0;
    endcase
  end

  assign w_nzp = alu_flags(32'(w_y), DATA_SIZE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_y         <= '0;
      r_cyo       <= 1'b0;
      r_ovf       <= 1'b0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_p         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              r_out_valid <= 1'b0;
              r_state     <= ST_MUL_BUSY;
            end else begin
              r_y                <= w_y;
              r_cyo              <= w_cyo;
              r_ovf              <= w_ovf;
              {r_n, r_z, r_p}    <= w_nzp;
              r_out_valid        <= 1'b1;
              r_state            <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && OUT_READY) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL_BUSY: begin
          if (w_mul_done) begin
            r_y             <= w_product[DATA_SIZE-1:0];
            r_cyo           <= |w_product[2*DATA_SIZE-1:DATA_SIZE];
            r_ovf           <= 1'b0;
            {r_n, r_z, r_p} <= w_mul_nzp;
            r_out_valid     <= 1'b1;
            r_state         <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign OUT_VALID = r_out_valid;
  assign Y         = r_y;
  assign CYO       = r_cyo;
  assign OVF       = r_ovf;
  assign N         = r_n;
  assign Z         = r_z;
  assign P         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Self-checking bench for alu_seq (DATA_SIZE=16), scoreboard based.
// Revision : 1.0
// ============================================================================
module tb_alu_seq;
  import alu_seq_pkg::*;

  typedef struct packed {
    logic [15:0] y;
    logic        cyo;
    logic        ovf;
    logic [5:0]  lat;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [2:0]  ALUK = 3'd0;
  logic [15:0] OP_A = 16'd0;
  logic [15:0] OP_B = 16'd0;
  logic        IN_READY;
  logic        OUT_VALID;
  logic [15:0] Y;
  logic        CYO;
  logic        OVF;
  logic        N;
  logic        Z;
  logic        P;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  alu_seq #(.DATA_SIZE(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ALUK      (ALUK),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Y         (Y),
    .CYO       (CYO),
    .OVF       (OVF),
    .N         (N),
    .Z         (Z),
    .P         (P)
  );

  function automatic logic [2:0] nzp_of(input logic [15:0] y);
    return {y[15], y == 16'd0, !y[15] && (y != 16'd0)};
  endfunction

  function automatic exp_t mk(input logic [15:0] y, input logic cyo,
                              input logic ovf, input int lat);
    exp_t e;
    e.y   = y;
    e.cyo = cyo;
    e.ovf = ovf;
    e.lat = 6'(lat);
    return e;
  endfunction

  // Reference model built on integer arithmetic rather than bit slicing.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t   e;
    int     ua, ub, sa, sbv, r, sh;
    longint pr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    e   = mk(16'd0, 1'b0, 1'b0, 1);
    case (op)
      3'd0: begin
        r     = ua + ub;
        e.y   = r[15:0];
        e.cyo = (r > 65535);
        e.ovf = ((sa + sbv) > 32767) || ((sa + sbv) < -32768);
      end
      3'd1: e.y = a & b;
      3'd2: e.y = ~a;
      3'd4: begin
        r     = ua - ub;
        e.y   = r[15:0];
        e.cyo = (ua >= ub);
        e.ovf = ((sa - sbv) > 32767) || ((sa - sbv) < -32768);
      end
      3'd5: e.y = a ^ b;
      3'd6: begin
        sh    = int'(b[3:0]);
        e.y   = a << sh;
        e.cyo = (sh == 0) ? 1'b0 : a[16 - sh];
      end
      3'd7: begin
`ifdef ALU_SEQ_MUL_EN
        pr    = longint'(ua) * longint'(ub);
        e.y   = pr[15:0];
        e.cyo = (pr[31:16] != 16'd0);
        e.lat = 6'd17;
`else
        pr    = 0;
        e.y   = 16'd0;
`endif
      end
      default: e.y = 16'd0;
    endcase
    return e;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick();
    checks++;
    if ({OUT_VALID, Y, CYO, OVF, N, Z, P} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b y=%h cyo=%b ovf=%b nzp=%b%b%b want all 0",
               OUT_VALID, Y, CYO, OVF, N, Z, P);
    end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_op(input string name, input logic [2:0] op,
                                input logic [15:0] a, input logic [15:0] b,
                                input exp_t e);
    exp_t got_e;
    int   lat;
    bit   rdy_seen;
    ALUK = op;
    OP_A = a;
    OP_B = b;
    IN_VALID = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: got %b want 1", name, IN_READY);
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    OP_A = ~a;
    OP_B = ~b;
    lat = 1;
    rdy_seen = 1'b0;
    while (OUT_VALID !== 1'b1 && lat < 40) begin
      if (IN_READY !== 1'b0) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    got_e = sb.pop_front();
    checks++;
    if (lat != int'(got_e.lat)) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, got_e.lat);
    end
    if (got_e.lat > 6'd1) begin
      checks++;
      if (rdy_seen) begin
        errors++;
        $display("FAIL %s_busy_ready: got IN_READY=1 while busy want 0", name);
      end
    end
    checks++;
    if (Y !== got_e.y) begin
      errors++;
      $display("FAIL %s_y: got %h want %h", name, Y, got_e.y);
    end
    checks++;
    if ({CYO, OVF} !== {got_e.cyo, got_e.ovf}) begin
      errors++;
      $display("FAIL %s_cyo_ovf: got %b%b want %b%b", name, CYO, OVF, got_e.cyo, got_e.ovf);
    end
    checks++;
    if ({N, Z, P} !== nzp_of(got_e.y)) begin
      errors++;
      $display("FAIL %s_nzp: got %b%b%b want %b", name, N, Z, P, nzp_of(got_e.y));
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume: got OUT_VALID=%b want 0", name, OUT_VALID);
    end
  endtask

  task automatic test_arith;
    test_single_op("add_wrap",   OP_ADD, 16'hFFFF, 16'h0001, mk(16'h0000, 1, 0, 1));
    test_single_op("add_ovf",    OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 0, 1, 1));
    test_single_op("sub_ovf",    OP_SUB, 16'h8000, 16'h0001, mk(16'h7FFF, 1, 1, 1));
    test_single_op("sub_borrow", OP_SUB, 16'h0000, 16'h0001, mk(16'hFFFF, 0, 0, 1));
  endtask

  task automatic test_logic_shift;
    test_single_op("and",       OP_AND,  16'hF0F0, 16'hFF00, mk(16'hF000, 0, 0, 1));
    test_single_op("not",       OP_NOT,  16'h00FF, 16'h1234, mk(16'hFF00, 0, 0, 1));
    test_single_op("zero",      OP_ZERO, 16'h5555, 16'hAAAA, mk(16'h0000, 0, 0, 1));
    test_single_op("shl_out1",  OP_SHL,  16'h8001, 16'h0001, mk(16'h0002, 1, 0, 1));
    test_single_op("shl_zero",  OP_SHL,  16'h1234, 16'h0000, mk(16'h1234, 0, 0, 1));
    test_single_op("shl_mask",  OP_SHL,  16'h0003, 16'h0013, mk(16'h0018, 0, 0, 1));
    test_single_op("shl_last",  OP_SHL,  16'h4000, 16'h0002, mk(16'h0000, 1, 0, 1));
  endtask

  task automatic test_mul;
`ifdef ALU_SEQ_MUL_EN
    test_single_op("mul_small", OP_MUL, 16'h0123, 16'h0010, mk(16'h1230, 0, 0, 17));
    test_single_op("mul_carry", OP_MUL, 16'hFFFF, 16'h0002, mk(16'hFFFE, 1, 0, 17));
`else
    test_single_op("mul_off",   OP_MUL, 16'h1234, 16'h5678, mk(16'h0000, 0, 0, 1));
`endif
  endtask

  task automatic test_back_to_back;
    exp_t e;
    logic [2:0] op;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op = (i == 50) ? OP_ZERO : 3'($urandom_range(0, 6));
      ALUK = op;
      OP_A = 16'($urandom);
      OP_B = 16'($urandom);
      #1;
      checks++;
      if (IN_READY !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, IN_READY);
      end
      sb.push_back(model(op, OP_A, OP_B));
      tick();
      e = sb.pop_front();
      checks++;
      if (OUT_VALID !== 1'b1 || Y !== e.y || {CYO, OVF} !== {e.cyo, e.ovf} ||
          {N, Z, P} !== nzp_of(e.y)) begin
        errors++;
        $display("FAIL b2b_result[%0d] op=%0d: got v=%b y=%h c/o=%b%b nzp=%b%b%b want v=1 y=%h c/o=%b%b",
                 i, op, OUT_VALID, Y, CYO, OVF, N, Z, P, e.y, e.cyo, e.ovf);
      end
    end
    IN_VALID = 1'b0;
    tick();
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got OUT_VALID=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_backpressure;
    exp_t e;
    ALUK = OP_XOR;
    OP_A = 16'hF0F0;
    OP_B = 16'h0FF0;
    IN_VALID = 1'b1;
    OUT_READY = 1'b0;
    #1;
    sb.push_back(mk(16'hFF00, 0, 0, 1));
    tick();
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      ALUK = OP_ADD;
      OP_A = 16'($urandom);
      OP_B = 16'($urandom);
      #1;
      checks++;
      if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || Y !== e.y ||
          {CYO, OVF} !== {e.cyo, e.ovf} || {N, Z, P} !== nzp_of(e.y)) begin
        errors++;
        $display("FAIL stall[%0d]: got v=%b rdy=%b y=%h nzp=%b%b%b want v=1 rdy=0 y=%h nzp=%b",
                 i, OUT_VALID, IN_READY, Y, N, Z, P, e.y, nzp_of(e.y));
      end
      tick();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0 || Y !== 16'hFF00) begin
      errors++;
      $display("FAIL stall_release: got v=%b y=%h want v=0 y=ff00", OUT_VALID, Y);
    end
  endtask

  task automatic test_reset_midway;
    bit seen;
    // Y still holds FF00 here, so a cleared Y proves the async reset.
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({OUT_VALID, Y, CYO, OVF, N, Z, P} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got v=%b y=%h nzp=%b%b%b want all 0", OUT_VALID, Y, N, Z, P);
    end
    tick();
    RST_N = 1'b1;
    tick();
`ifdef ALU_SEQ_MUL_EN
    ALUK = OP_MUL;
    OP_A = 16'h0123;
    OP_B = 16'h0010;
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    tick();
    IN_VALID = 1'b0;
    repeat (7) tick();
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({OUT_VALID, Y, CYO, OVF, N, Z, P} !== 22'd0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL mul_reset: got v=%b y=%h rdy=%b want all 0 rdy=1", OUT_VALID, Y, IN_READY);
    end
    tick();
    RST_N = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (OUT_VALID !== 1'b0) seen = 1'b1;
    end
    OUT_READY = 1'b0;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mul_reset_discard: got OUT_VALID=1 after release want 0");
    end
`else
    seen = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the team's 3-op combinational ALU.
- Widens the opcode to 8 operations and registers the result behind a valid/ready handshake.
- Adds a multi-cycle shift-add multiplier.
- Produces N/Z/P condition flags, carry and signed overflow.
- Sits between the register-file read stage and the writeback mux of the CPU datapath.

Parameters:
- DATA_SIZE, 16, operand/result width; legal range 4..32.
- CNT_W, $clog2(DATA_SIZE)+1, multiplier step-counter width (derived; do not override).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  operation request
- IN_READY  out  1  block can accept a request this cycle
- ALUK  in  3  opcode
- OP_A  in  DATA_SIZE  operand A
- OP_B  in  DATA_SIZE  operand B
- OUT_VALID  out  1  Y and flags are valid
- OUT_READY  in  1  consumer takes the result
- Y  out  DATA_SIZE  registered result
- CYO  out  1  carry / unsigned overflow
- OVF  out  1  signed overflow
- N, Z, P  out  1 each  sign flags of Y; exactly one is high while OUT_VALID

Behaviour:
- Opcodes:
  - 000 ADD: A+B
  - 001 AND
  - 010 NOT A
  - 011 ZERO: Y=0, kept for backward compatibility
  - 100 SUB: A+~B+1
  - 101 XOR
  - 110 SHL: A<<B[CNT_W-2:0]
  - 111 MUL: low DATA_SIZE bits of unsigned A*B
- Arithmetic/width rules:
  - ADD/SUB: CYO = carry out of bit DATA_SIZE-1; for SUB, CYO=1 means no borrow.
  - ADD/SUB: OVF = two's-complement overflow.
  - MUL: CYO=1 if the upper DATA_SIZE bits of the 2*DATA_SIZE product are nonzero; OVF=0.
  - SHL: CYO = last bit shifted out (0 for shift of 0); OVF=0.
  - Logic ops and ZERO: CYO=0, OVF=0.
- Flags: N=Y[MSB]; Z=(Y==0); P=!N&&!Z.
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE: IN_READY=1. On accept (IN_VALID&&IN_READY):
    - non-MUL op: compute and register, go to DONE.
    - MUL: latch operands, clear 2N accumulator, counter=0, go to MUL_BUSY.
  - MUL_BUSY: IN_READY=0. Each cycle:
    - if B[0], add the shifted multiplicand into the accumulator;
    - shift multiplicand left and B right; counter++.
    - After DATA_SIZE steps, register the result, go to DONE.
  - DONE: OUT_VALID=1; Y/flags held stable until OUT_READY.
    - OUT_READY with no new accept: go to IDLE.
    - OUT_READY with simultaneous IN_VALID: IN_READY=1 and the new request is accepted in the same cycle. Non-MUL stays in DONE with the new result; MUL goes to MUL_BUSY.
    - Sustained throughput for non-MUL ops is 1 per cycle.
- Latency, measured from the accept edge to OUT_VALID: non-MUL 1 cycle; MUL DATA_SIZE+1 cycles.
- Inputs are sampled only at accept; OP_A/OP_B/ALUK changes at other times are ignored.
- Reset, including mid-MUL:
  - state=IDLE, counter=0;
  - Y=0, CYO=0, OVF=0, N=0, Z=0, P=0, OUT_VALID=0;
  - any in-flight operation is discarded.
- IN_VALID while IN_READY=0 is not an error; the request simply waits.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: opcode 111 runs the multiplier as above; MUL_BUSY state and alu_mul_seq are present.
- Undefined:
  - multiplier logic and MUL_BUSY are not built;
  - opcode 111 completes in 1 cycle like ZERO (Y=0, CYO=0, OVF=0, Z=1).

Decomposition:
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (3-bit);
  - FSM state encodings ST_IDLE/ST_MUL_BUSY/ST_DONE;
  - a flag-generation function (N/Z/P from a DATA_SIZE value).
- Sub-module alu_mul_seq, parametrised by DATA_SIZE:
  - ports: start, A, B, busy, done, product[2*DATA_SIZE-1:0];
  - compiled only under ALU_SEQ_MUL_EN.
- The top level keeps the handshake FSM and the single-cycle datapath.

Test Plan (DATA_SIZE=16):
- ADD A=FFFF B=0001 -> one cycle after accept: OUT_VALID=1, Y=0000, CYO=1, OVF=0, Z=1.
- SUB A=8000 B=0001 -> Y=7FFF, OVF=1, CYO=1, P=1; SUB A=0000 B=0001 -> Y=FFFF, CYO=0, N=1.
- MUL A=0123 B=0010 -> Y=1230, CYO=0, OUT_VALID exactly 17 cycles after accept, IN_READY=0 throughout; MUL A=FFFF B=0002 -> Y=FFFE, CYO=1.
- Back-to-back: IN_VALID and OUT_READY held high, 100 random non-MUL ops -> one result per cycle, each matching a reference model; ALUK=011 -> Y=0.
- Backpressure: after an XOR result (A=F0F0 B=0FF0 -> Y=FF00), hold OUT_READY=0 for 5 cycles while OP_A/OP_B toggle -> Y/flags stable, IN_READY=0, no request accepted.
- Reset: assert RST_N=0 at step 8 of a MUL -> all outputs 0 immediately, no OUT_VALID after release. With ALU_SEQ_MUL_EN undefined, ALUK=111 -> Y=0, Z=1 after 1 cycle.
